// File: rtl/up_tpl_pkg.sv
// rtl/up_tpl_pkg.sv - shared types and constants for the TPL register-bus fan-out
package up_tpl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } resp_state_t;

    localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hDEADDEAD;
    localparam int          ERR_CNT_W             = 16;

    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] cnt,
                                                     input logic [1:0]           inc);
        logic [ERR_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(ERR_CNT_W-1){1'b0}}, inc};
        return sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : sum[ERR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/up_tpl_bus_fanout_if.sv
// rtl/up_tpl_bus_fanout_if.sv - up-bus and slice-side signal bundle for the fan-out stage
interface up_tpl_bus_fanout_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 14
);
    logic                       up_wreq;
    logic [ADDR_WIDTH-1:0]      up_waddr;
    logic [31:0]                up_wdata;
    logic                       up_wack;
    logic                       up_rreq;
    logic [ADDR_WIDTH-1:0]      up_raddr;
    logic                       up_rack;
    logic [31:0]                up_rdata;

    logic                       s_wreq;
    logic [ADDR_WIDTH-1:0]      s_waddr;
    logic [31:0]                s_wdata;
    logic [NUM_SLAVES-1:0]      s_wack;
    logic                       s_rreq;
    logic [ADDR_WIDTH-1:0]      s_raddr;
    logic [NUM_SLAVES-1:0]      s_rack;
    logic [NUM_SLAVES*32-1:0]   s_rdata;

    // master: up_axi side plus the slices; slave: the fan-out stage itself
    modport master (
        output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr, s_wack, s_rack, s_rdata,
        input  up_wack, up_rack, up_rdata, s_wreq, s_waddr, s_wdata, s_rreq, s_raddr
    );

    modport slave (
        input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr, s_wack, s_rack, s_rdata,
        output up_wack, up_rack, up_rdata, s_wreq, s_waddr, s_wdata, s_rreq, s_raddr
    );
endinterface

// File: rtl/up_tpl_bus_resp_tracker.sv
// rtl/up_tpl_bus_resp_tracker.sv - one-direction request/ack tracker with response timeout
module up_tpl_bus_resp_tracker
    import up_tpl_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [NUM_SLAVES-1:0] ack,
    output logic                  idle,
    output logic                  resp,
    output logic                  done,
    output logic                  timeout,
    output logic                  multi
);
    localparam int                  CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_SLAVES-1:0] ONE   = NUM_SLAVES'(1);

    resp_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             any_ack;

    // An ack in the last wait cycle takes precedence over the timeout
    always_comb begin
        any_ack = |ack;
        idle    = (state == ST_IDLE);
        timeout = !idle && !any_ack && (cnt == CNT_MAX);
        done    = !idle && (any_ack || (cnt == CNT_MAX));
        multi   = !idle && ((ack & (ack - ONE)) != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            resp  <= 1'b0;
        end else begin
            resp <= done;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/up_tpl_bus_fanout.sv
// rtl/up_tpl_bus_fanout.sv - registered request broadcast and masked response collection for TPL slices
module up_tpl_bus_fanout
    import up_tpl_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter int          ADDR_WIDTH     = 14,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_RDATA  = TIMEOUT_RDATA_DEFAULT
) (
    input  logic                 up_clk,
    input  logic                 up_rst,
    up_tpl_bus_fanout_if.slave   bus,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_timeout_cnt,
    output logic [ERR_CNT_W-1:0] err_multi_ack_cnt
);
    logic        w_idle, w_resp, w_done, w_timeout, w_multi;
    logic        r_idle, r_resp, r_done, r_timeout, r_multi;
    logic [31:0] rdata_mask;
    logic [1:0]  to_inc, mu_inc;

    up_tpl_bus_resp_tracker #(.NUM_SLAVES(NUM_SLAVES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr (
        .clk(up_clk), .rst(up_rst), .req(bus.up_wreq), .ack(bus.s_wack),
        .idle(w_idle), .resp(w_resp), .done(w_done), .timeout(w_timeout), .multi(w_multi)
    );

    up_tpl_bus_resp_tracker #(.NUM_SLAVES(NUM_SLAVES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd (
        .clk(up_clk), .rst(up_rst), .req(bus.up_rreq), .ack(bus.s_rack),
        .idle(r_idle), .resp(r_resp), .done(r_done), .timeout(r_timeout), .multi(r_multi)
    );

    assign bus.up_wack = w_resp;
    assign bus.up_rack = r_resp;

    // Requests arriving while a direction is busy are dropped, so they are not broadcast either
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            bus.s_wreq  <= 1'b0;
            bus.s_waddr <= {ADDR_WIDTH{1'b0}};
            bus.s_wdata <= '0;
            bus.s_rreq  <= 1'b0;
            bus.s_raddr <= {ADDR_WIDTH{1'b0}};
        end else begin
            bus.s_wreq <= bus.up_wreq && w_idle;
            bus.s_rreq <= bus.up_rreq && r_idle;
            if (bus.up_wreq && w_idle) begin
                bus.s_waddr <= bus.up_waddr;
                bus.s_wdata <= bus.up_wdata;
            end
            if (bus.up_rreq && r_idle) begin
                bus.s_raddr <= bus.up_raddr;
            end
        end
    end

    always_comb begin
        rdata_mask = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (bus.s_rack[i]) begin
                rdata_mask = rdata_mask | bus.s_rdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            bus.up_rdata <= '0;
        end else if (r_done) begin
            bus.up_rdata <= r_timeout ? TIMEOUT_RDATA : rdata_mask;
        end
    end

    assign to_inc = {1'b0, w_timeout} + {1'b0, r_timeout};
    assign mu_inc = {1'b0, w_multi && w_done} + {1'b0, r_multi && r_done};

    always_ff @(posedge up_clk) begin
        if (up_rst || err_clr) begin
            err_timeout_cnt   <= '0;
            err_multi_ack_cnt <= '0;
        end else begin
            err_timeout_cnt   <= sat_add(err_timeout_cnt, to_inc);
            err_multi_ack_cnt <= sat_add(err_multi_ack_cnt, mu_inc);
        end
    end
endmodule

// File: tb/tb_up_tpl_bus_fanout.sv
// tb/tb_up_tpl_bus_fanout.sv - scoreboard bench for the TPL register-bus fan-out stage
module tb_up_tpl_bus_fanout;
    localparam int NS = 4;
    localparam int AW = 14;
    localparam int TO = 64;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        up_clk = 1'b0;
    logic        up_rst;
    logic        err_clr;
    logic [15:0] err_timeout_cnt;
    logic [15:0] err_multi_ack_cnt;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t wq[$];
    exp_t rq[$];

    up_tpl_bus_fanout_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW)) bus ();

    up_tpl_bus_fanout #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(32'hDEADDEAD)
    ) dut (
        .up_clk(up_clk),
        .up_rst(up_rst),
        .bus(bus),
        .err_clr(err_clr),
        .err_timeout_cnt(err_timeout_cnt),
        .err_multi_ack_cnt(err_multi_ack_cnt)
    );

    always #5 up_clk = ~up_clk;

    always @(posedge up_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge up_clk);
    endtask

    // Response monitor: every up_*ack must match the oldest queued expectation
    always @(negedge up_clk) begin
        exp_t e;
        if (bus.up_wack === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wack_unexpected: got wack=1 expected none (cycle %0d)", cyc);
            end else begin
                e = wq.pop_front();
                check("wack_cycle", cyc, e.cyc);
            end
        end
        if (bus.up_rack === 1'b1) begin
            if (rq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rack_unexpected: got rack=1 expected none (cycle %0d)", cyc);
            end else begin
                e = rq.pop_front();
                check("rack_cycle", cyc, e.cyc);
                check("rack_rdata", bus.up_rdata, e.data);
            end
        end
    end

    initial begin
        int t0;
        bus.up_wreq  = 1'b0;
        bus.up_waddr = '0;
        bus.up_wdata = '0;
        bus.up_rreq  = 1'b0;
        bus.up_raddr = '0;
        bus.s_wack   = '0;
        bus.s_rack   = '0;
        bus.s_rdata  = '0;
        err_clr      = 1'b0;
        up_rst       = 1'b1;

        tick(3);
        check("rst_up_wack", bus.up_wack, 0);
        check("rst_up_rack", bus.up_rack, 0);
        check("rst_up_rdata", bus.up_rdata, 0);
        check("rst_s_wreq", bus.s_wreq, 0);
        check("rst_s_rreq", bus.s_rreq, 0);
        check("rst_s_waddr", bus.s_waddr, 0);
        check("rst_err_to", err_timeout_cnt, 0);
        check("rst_err_mu", err_multi_ack_cnt, 0);
        up_rst = 1'b0;
        tick(2);

        // Single slice read, other slices' data masked
        t0 = cyc;
        bus.s_rdata  = {32'hAAAA0003, 32'h12345678, 32'h55550001, 32'hFFFF0000};
        bus.up_rreq  = 1'b1;
        bus.up_raddr = 14'h010;
        rq.push_back('{cyc: t0 + 2, data: 32'h12345678});
        tick();
        bus.up_rreq = 1'b0;
        check("s_rreq_pulse", bus.s_rreq, 1);
        check("s_raddr", bus.s_raddr, 14'h010);
        bus.s_rack = 4'b0100;
        tick();
        bus.s_rack = '0;
        check("s_rreq_single", bus.s_rreq, 0);
        tick(3);

        // Stray ack while idle, then write with no ack -> timeout
        bus.s_wack = 4'b0010;
        tick();
        bus.s_wack = '0;
        tick();
        t0 = cyc;
        bus.up_wreq  = 1'b1;
        bus.up_waddr = 14'h123;
        bus.up_wdata = 32'hCAFEF00D;
        wq.push_back('{cyc: t0 + TO + 1, data: 32'h0});
        tick();
        bus.up_wreq = 1'b0;
        check("s_wreq_pulse", bus.s_wreq, 1);
        check("s_waddr", bus.s_waddr, 14'h123);
        check("s_wdata", bus.s_wdata, 32'hCAFEF00D);
        tick(TO - 1);
        check("err_to_before_timeout", err_timeout_cnt, 0);
        tick();
        check("err_to_after_wr_timeout", err_timeout_cnt, 1);
        tick(2);

        // Two slices ack together
        t0 = cyc;
        bus.s_rdata = {32'h00000F00, 32'h80000000, 32'h00000001, 32'h000000F0};
        bus.up_rreq = 1'b1;
        bus.up_raddr = 14'h020;
        rq.push_back('{cyc: t0 + 2, data: 32'h00000FF0});
        tick();
        bus.up_rreq = 1'b0;
        bus.s_rack  = 4'b1001;
        tick();
        bus.s_rack = '0;
        check("err_mu_after_multi", err_multi_ack_cnt, 1);
        tick(2);

        // Simultaneous write and read timeouts
        t0 = cyc;
        bus.up_wreq = 1'b1;
        bus.up_rreq = 1'b1;
        wq.push_back('{cyc: t0 + TO + 1, data: 32'h0});
        rq.push_back('{cyc: t0 + TO + 1, data: 32'hDEADDEAD});
        tick();
        bus.up_wreq = 1'b0;
        bus.up_rreq = 1'b0;
        tick(TO);
        check("err_to_dual_timeout", err_timeout_cnt, 3);
        tick(2);

        // Ack in the final wait cycle beats the timeout
        t0 = cyc;
        bus.up_rreq = 1'b1;
        tick();
        bus.up_rreq = 1'b0;
        tick(TO - 1);
        bus.s_rack = 4'b0001;
        rq.push_back('{cyc: t0 + TO + 1, data: 32'h000000F0});
        tick();
        bus.s_rack = '0;
        check("err_to_late_ack", err_timeout_cnt, 3);
        check("err_mu_late_ack", err_multi_ack_cnt, 1);
        tick(2);

        // Second write while busy is dropped: only one response
        t0 = cyc;
        bus.up_wreq  = 1'b1;
        bus.up_waddr = 14'h200;
        tick();
        bus.up_wreq = 1'b0;
        tick(2);
        bus.up_wreq  = 1'b1;
        bus.up_waddr = 14'h3FF;
        tick();
        bus.up_wreq = 1'b0;
        tick();
        bus.s_wack = 4'b1000;
        wq.push_back('{cyc: t0 + 6, data: 32'h0});
        tick();
        bus.s_wack = '0;
        tick(4);

        // Saturation from 0xFFFE
        force dut.err_timeout_cnt = 16'hFFFE;
        tick();
        release dut.err_timeout_cnt;
        tick();
        check("err_to_preload", err_timeout_cnt, 16'hFFFE);
        t0 = cyc;
        bus.up_wreq = 1'b1;
        wq.push_back('{cyc: t0 + TO + 1, data: 32'h0});
        tick();
        bus.up_wreq = 1'b0;
        tick(TO);
        check("err_to_sat_first", err_timeout_cnt, 16'hFFFF);
        tick(2);
        t0 = cyc;
        bus.up_rreq = 1'b1;
        rq.push_back('{cyc: t0 + TO + 1, data: 32'hDEADDEAD});
        tick();
        bus.up_rreq = 1'b0;
        tick(TO);
        check("err_to_sat_hold", err_timeout_cnt, 16'hFFFF);
        tick(2);

        // Clear wins over a concurrent timeout
        t0 = cyc;
        bus.up_wreq = 1'b1;
        wq.push_back('{cyc: t0 + TO + 1, data: 32'h0});
        tick();
        bus.up_wreq = 1'b0;
        tick(TO - 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_to_clr_wins", err_timeout_cnt, 0);
        check("err_mu_clr", err_multi_ack_cnt, 0);
        tick(2);

        // Reset in WAIT, then an ack after release: no response
        bus.up_rreq = 1'b1;
        tick();
        bus.up_rreq = 1'b0;
        tick(4);
        up_rst = 1'b1;
        tick();
        up_rst = 1'b0;
        tick();
        bus.s_rack = 4'b0010;
        tick();
        bus.s_rack = '0;
        tick(TO + 5);
        check("rst_mid_up_rdata", bus.up_rdata, 0);
        check("rst_mid_s_rreq", bus.s_rreq, 0);
        check("rst_mid_s_raddr", bus.s_raddr, 0);
        check("rst_mid_err_to", err_timeout_cnt, 0);

        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/up_tpl_bus_fanout.md
# up_tpl_bus_fanout

Parametrised register-bus fan-out/fan-in stage between `up_axi` and the N register slices of a TPL core (common, per-channel, TPL-common). It replaces ad hoc OR-reduction of slice responses with registered request broadcast, masked response collection, a per-direction response timeout so a missing slice can never hang the AXI bus, and saturating error counters for timeouts and multi-slice acks. Read and write paths are independent.

## Interface
Parameters:
- `NUM_SLAVES`, 4: number of register slices (≥1).
- `ADDR_WIDTH`, 14: up-bus word-address width.
- `TIMEOUT_CYCLES`, 64: cycles to wait for a slice ack before forcing a response (≥2).
- `TIMEOUT_RDATA`, 32'hDEADDEAD: read data returned on timeout.

Ports:
- `up_clk`  in  1  register-bus clock; the only clock.
- `up_rst`  in  1  synchronous, active-high reset.
- `up_wreq` / `up_rreq`  in  1  single-cycle request pulses from `up_axi`.
- `up_waddr` / `up_raddr`  in  ADDR_WIDTH  request addresses.
- `up_wdata`  in  32  write data.
- `up_wack` / `up_rack`  out  1  single-cycle response pulses to `up_axi`.
- `up_rdata`  out  32  read data, valid with `up_rack`.
- `s_wreq` / `s_rreq`  out  1  broadcast requests to all slices.
- `s_waddr` / `s_raddr`  out  ADDR_WIDTH  broadcast addresses.
- `s_wdata`  out  32  broadcast write data.
- `s_wack` / `s_rack`  in  NUM_SLAVES  per-slice ack pulses.
- `s_rdata`  in  NUM_SLAVES*32  per-slice read data, slice i at `[32*i+:32]`.
- `err_clr`  in  1  clears both error counters.
- `err_timeout_cnt`  out  16  saturating count of timed-out transactions (both directions).
- `err_multi_ack_cnt`  out  16  saturating count of responses with >1 slice ack.

## Operation
- Reset: all outputs 0; both FSMs IDLE; timeout counters 0.
- Request stage: `s_*req` is `up_*req` registered; address/data registered on the same edge and held until the next request.
- Per-direction FSM, states IDLE, WAIT:
  - IDLE: `up_*req` → WAIT, wait counter cleared.
  - WAIT: counter increments each cycle. Any bit of `s_*ack` set → emit response, IDLE. Counter = TIMEOUT_CYCLES-1 with no ack → emit timeout response, increment `err_timeout_cnt`, IDLE.
  - Ack and timeout in the same cycle: ack wins; no timeout counted.
- Read data: OR of `s_rdata` words whose `s_rack` bit is set (non-acking slices masked). Timeout response returns TIMEOUT_RDATA.
- Multi-ack: popcount(`s_*ack`) > 1 in a response cycle → response still emitted (data ORed), `err_multi_ack_cnt` +1.
- Write and read timeouts in the same cycle: `err_timeout_cnt` +2, saturating.
- Stray acks while IDLE: ignored, not counted.
- New request while WAIT in same direction: dropped (protocol violation), no response generated for it.
- Counters saturate at 16'hFFFF; `err_clr` sets to 0 and has priority over concurrent increments.
- Reset mid-transaction: FSM → IDLE, no response emitted; later acks ignored.

## Timing
- `up_wreq` at cycle 0 → `s_wreq` high for exactly cycle 1.
- Slice ack at cycle k (k ≥ 1) → `up_*ack` high for exactly cycle k+1; `up_rdata` valid that cycle and holds until the next `up_rack`.
- No ack → `up_*ack` at cycle TIMEOUT_CYCLES+1.
- Minimum request-to-response latency: 2 cycles (slice acking in cycle 1).
- Error counters update in the cycle the response is emitted.

## Structure
- Shared package `up_tpl_pkg`: FSM state encoding (IDLE, WAIT), default TIMEOUT_RDATA constant, counter width constant (16).
- Sub-module `up_tpl_bus_resp_tracker`: one-direction FSM + wait counter + ack detect/popcount>1 flag; instantiated twice (write, read with data-masking enabled). Top holds request registers, rdata OR-mask, and error counters.

## Test plan
- NUM_SLAVES=4, read addr 0x010, slice 2 acks in cycle 1 with 0x12345678 → `up_rack` cycle 2, `up_rdata`=0x12345678; other slices' nonzero non-acked data masked.
- Write with no slice acking, TIMEOUT_CYCLES=64 → `up_wack` cycle 65, `err_timeout_cnt`=1.
- Read: slices 0 and 3 ack together with 0x00F0 and 0x0F00 → `up_rdata`=0x0FF0, `err_multi_ack_cnt`=1.
- Simultaneous write and read, no acks → both acks cycle 65, `err_timeout_cnt`=2; ack arriving exactly at cycle 64 → normal response, count unchanged.
- Force counter to 0xFFFE, two timeouts → 0xFFFF; `err_clr` concurrent with a timeout → 0.
- `up_rst` asserted in WAIT, slice acks one cycle after release → no `up_rack`, all outputs 0.
